// File: rtl/dvp_capture.sv
// dvp_capture: oversampled receive stage for a CMOS parallel pixel bus.
// Bytes captured on pixel-clock rising edges are packed into 32-bit words,
// tagged with sof/eol/keep, and queued in a 4-entry fall-through FIFO.
// Line and frame lengths are checked against EXP_PIX / EXP_LINES.
module dvp_capture #(
  parameter int unsigned EXP_PIX   = 100,
  parameter int unsigned EXP_LINES = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cam_pclk,
  input  logic        cam_fval,
  input  logic        cam_lval,
  input  logic [7:0]  cam_data,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [11:0] stat_pix,
  output logic [11:0] stat_lines,
  output logic        err_line,
  output logic        err_frame,
  output logic        overflow
);

  localparam logic [11:0] LP_EXP_PIX   = 12'(EXP_PIX);
  localparam logic [11:0] LP_EXP_LINES = 12'(EXP_LINES);
  localparam logic [11:0] LP_CNT_MAX   = 12'hFFF;

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_WAIT_FS  = 2'd1,
    ST_FRAME    = 2'd2,
    ST_LINE     = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  // Synchronizers and pclk edge history
  logic       r_pclk_m, r_pclk_s, r_pclk_d;
  logic       r_fval_m, r_fval_s;
  logic       r_lval_m, r_lval_s;
  logic [7:0] r_data_m, r_data_s;
  logic       w_ev;

  // FSM decode
  logic w_capture, w_line_end, w_frame_end, w_sof_arm;

  // Packing
  logic [31:0] r_asm;
  logic [1:0]  r_lane;
  logic [31:0] r_pend_data;
  logic        r_pend_v;
  logic        r_sof_pend;
  logic [31:0] r_tail_data;
  logic [3:0]  r_tail_keep;
  logic        r_tail_v;
  logic [31:0] r_wr_data;
  logic [3:0]  r_wr_keep;
  logic        r_wr_sof;
  logic        r_wr_eol;
  logic        r_wr_v;
  logic [3:0]  w_part_keep;

  // Counters
  logic [11:0] r_pix_cnt, r_line_cnt;
  logic [11:0] w_pix_inc, w_line_inc, w_lines_final;

  // FIFO
  logic [37:0] r_mem [4];
  logic [1:0]  r_wptr, r_rptr;
  logic [2:0]  r_count;
  logic        w_full, w_rd, w_wr;

  // Two-flop synchronizers plus a third pclk stage for edge detection
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pclk_m <= 1'b0; r_pclk_s <= 1'b0; r_pclk_d <= 1'b0;
      r_fval_m <= 1'b0; r_fval_s <= 1'b0;
      r_lval_m <= 1'b0; r_lval_s <= 1'b0;
      r_data_m <= '0;   r_data_s <= '0;
    end else begin
      r_pclk_m <= cam_pclk; r_pclk_s <= r_pclk_m; r_pclk_d <= r_pclk_s;
      r_fval_m <= cam_fval; r_fval_s <= r_fval_m;
      r_lval_m <= cam_lval; r_lval_s <= r_lval_m;
      r_data_m <= cam_data; r_data_s <= r_data_m;
    end
  end

  assign w_ev = r_pclk_s & ~r_pclk_d;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= ST_WAIT_LOW;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and per-event capture/line/frame decisions
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_line_end  = 1'b0;
    w_frame_end = 1'b0;
    w_sof_arm   = 1'b0;
    if (w_ev) begin
      case (r_state)
        ST_WAIT_LOW: if (!r_fval_s) w_state_nxt = ST_WAIT_FS;
        ST_WAIT_FS: if (r_fval_s) begin
          w_state_nxt = ST_FRAME;
          w_sof_arm   = 1'b1;
        end
        ST_FRAME: begin
          if (!r_fval_s) begin
            w_frame_end = 1'b1;
            w_state_nxt = ST_WAIT_FS;
          end else if (r_lval_s) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_LINE;
          end
        end
        ST_LINE: begin
          if (!r_fval_s) begin
            w_line_end  = 1'b1;
            w_frame_end = 1'b1;
            w_state_nxt = ST_WAIT_FS;
          end else if (!r_lval_s) begin
            w_line_end  = 1'b1;
            w_state_nxt = ST_FRAME;
          end else begin
            w_capture   = 1'b1;
          end
        end
        default: w_state_nxt = ST_WAIT_LOW;
      endcase
    end
  end

  // Keep mask for a partial word, from the number of lanes filled
  always_comb begin
    w_part_keep = 4'b0000;
    case (r_lane)
      2'd1:    w_part_keep = 4'b0001;
      2'd2:    w_part_keep = 4'b0011;
      2'd3:    w_part_keep = 4'b0111;
      default: w_part_keep = 4'b0000;
    endcase
  end

  // Byte packing, pending word and FIFO write staging.
  // A line end with both a pending and a partial word stages the pending
  // word first and parks the partial in r_tail, written the next cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_asm <= '0; r_lane <= '0;
      r_pend_data <= '0; r_pend_v <= 1'b0; r_sof_pend <= 1'b0;
      r_tail_data <= '0; r_tail_keep <= '0; r_tail_v <= 1'b0;
      r_wr_data <= '0; r_wr_keep <= '0; r_wr_sof <= 1'b0; r_wr_eol <= 1'b0;
      r_wr_v <= 1'b0;
    end else begin
      r_wr_v <= 1'b0;
      if (w_sof_arm) r_sof_pend <= 1'b1;
      if (r_tail_v) begin
        r_wr_data <= r_tail_data; r_wr_keep <= r_tail_keep;
        r_wr_sof  <= 1'b0;        r_wr_eol  <= 1'b1;
        r_wr_v    <= 1'b1;        r_tail_v  <= 1'b0;
      end
      if (w_capture) begin
        if (r_pend_v) begin
          r_wr_data  <= r_pend_data; r_wr_keep <= 4'b1111;
          r_wr_sof   <= r_sof_pend;  r_wr_eol  <= 1'b0;
          r_wr_v     <= 1'b1;        r_sof_pend <= 1'b0;
          r_pend_v   <= 1'b0;
        end
        if (r_lane == 2'd3) begin
          r_pend_data <= {r_data_s, r_asm[23:0]};
          r_pend_v    <= 1'b1;
          r_asm       <= '0;
        end else begin
          r_asm[{r_lane, 3'b000} +: 8] <= r_data_s;
        end
        r_lane <= r_lane + 2'd1;
      end
      if (w_line_end) begin
        if (r_lane != 2'd0) begin
          if (r_pend_v) begin
            r_wr_data   <= r_pend_data; r_wr_keep   <= 4'b1111;
            r_wr_eol    <= 1'b0;
            r_tail_data <= r_asm;       r_tail_keep <= w_part_keep;
            r_tail_v    <= 1'b1;
          end else begin
            r_wr_data <= r_asm;         r_wr_keep <= w_part_keep;
            r_wr_eol  <= 1'b1;
          end
          r_wr_sof   <= r_sof_pend;
          r_wr_v     <= 1'b1;
          r_sof_pend <= 1'b0;
        end else if (r_pend_v) begin
          r_wr_data  <= r_pend_data; r_wr_keep <= 4'b1111;
          r_wr_sof   <= r_sof_pend;  r_wr_eol  <= 1'b1;
          r_wr_v     <= 1'b1;        r_sof_pend <= 1'b0;
        end
        r_pend_v <= 1'b0;
        r_asm    <= '0;
        r_lane   <= '0;
      end
    end
  end

  assign w_pix_inc     = (r_pix_cnt  == LP_CNT_MAX) ? r_pix_cnt  : r_pix_cnt  + 12'd1;
  assign w_line_inc    = (r_line_cnt == LP_CNT_MAX) ? r_line_cnt : r_line_cnt + 12'd1;
  assign w_lines_final = w_line_end ? w_line_inc : r_line_cnt;

  // Saturating byte/line counters, status registers and error pulses
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pix_cnt <= '0; r_line_cnt <= '0;
      stat_pix <= '0; stat_lines <= '0;
      frame_done <= 1'b0; err_line <= 1'b0; err_frame <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
      if (w_capture) r_pix_cnt <= w_pix_inc;
      if (w_line_end) begin
        stat_pix   <= r_pix_cnt;
        err_line   <= (r_pix_cnt != LP_EXP_PIX);
        r_pix_cnt  <= '0;
        r_line_cnt <= w_line_inc;
      end
      if (w_frame_end) begin
        stat_lines <= w_lines_final;
        frame_done <= 1'b1;
        err_frame  <= (w_lines_final != LP_EXP_LINES);
        r_line_cnt <= '0;
      end
    end
  end

  assign w_full = (r_count == 3'd4);
  assign w_rd   = out_valid & out_ready;
  assign w_wr   = r_wr_v & (~w_full | w_rd);

  // Output FIFO; a write at full is accepted only when a read frees a slot
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wptr <= '0; r_rptr <= '0; r_count <= '0; overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= {r_wr_data, r_wr_keep, r_wr_sof, r_wr_eol};
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_rd) r_rptr <= r_rptr + 2'd1;
      if (w_wr && !w_rd)      r_count <= r_count + 3'd1;
      else if (!w_wr && w_rd) r_count <= r_count - 3'd1;
      if (r_wr_v && !w_wr) overflow <= 1'b1;
    end
  end

  assign out_valid = (r_count != 3'd0);
  assign {out_data, out_keep, out_sof, out_eol} = r_mem[r_rptr];

endmodule

// File: tb/tb_dvp_capture.sv
// tb_dvp_capture: directed frames on the pixel bus with hand-computed words,
// status values and pulse counts.
module tb_dvp_capture;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cam_pclk, cam_fval, cam_lval;
  logic [7:0]  cam_data;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_sof, out_eol, out_valid, out_ready;
  logic        frame_done, err_line, err_frame, overflow;
  logic [11:0] stat_pix, stat_lines;

  dvp_capture #(.EXP_PIX(100), .EXP_LINES(10)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cam_pclk(cam_pclk), .cam_fval(cam_fval), .cam_lval(cam_lval),
    .cam_data(cam_data),
    .out_data(out_data), .out_keep(out_keep), .out_sof(out_sof),
    .out_eol(out_eol), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .stat_pix(stat_pix), .stat_lines(stat_lines),
    .err_line(err_line), .err_frame(err_frame), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] wd(input logic [31:0] d, input logic [3:0] k,
                                     input logic s, input logic e);
    return {d, k, s, e};
  endfunction

  logic [37:0] q[$];
  int unsigned n_fd = 0, n_el = 0, n_ef = 0;
  logic        held_v = 1'b0;
  logic [37:0] held;

  // Collect accepted words, count pulses, and check stability under backpressure
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      held_v = 1'b0;
    end else begin
      if (frame_done) n_fd++;
      if (err_line)   n_el++;
      if (err_frame)  n_ef++;
      if (out_valid && out_ready) q.push_back({out_data, out_keep, out_sof, out_eol});
      if (out_valid && !out_ready) begin
        if (held_v) chk("hold", {out_data, out_keep, out_sof, out_eol}, held);
        held   = {out_data, out_keep, out_sof, out_eol};
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // One pixel-clock period (10 sys_clk): inputs change with pclk low
  task automatic pix(input logic f, input logic l, input logic [7:0] d);
    cam_pclk = 1'b0; cam_fval = f; cam_lval = l; cam_data = d;
    #50;
    cam_pclk = 1'b1;
    #50;
  endtask

  // Frame of nlines; last line has last_pix bytes; abrupt ends with lval still high
  task automatic send_frame(input int nlines, input int npix, input int last_pix,
                            input logic [7:0] base, input bit abrupt);
    pix(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < nlines; l++) begin
      int n;
      n = (l == nlines - 1) ? last_pix : npix;
      for (int i = 0; i < n; i++) pix(1'b1, 1'b1, 8'(int'(base) + i));
      if (!(abrupt && l == nlines - 1)) begin
        pix(1'b1, 1'b0, 8'h00);
        pix(1'b1, 1'b0, 8'h00);
      end
    end
    pix(1'b0, abrupt, 8'h00);
    repeat (4) pix(1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_obs();
    q.delete();
    n_fd = 0; n_el = 0; n_ef = 0;
  endtask

  initial begin
    int n_eol, n_sof;
    sys_rst = 1'b1; out_ready = 1'b1;
    cam_pclk = 1'b0; cam_fval = 1'b1; cam_lval = 1'b0; cam_data = 8'h00;
    #7;
    // Reset held while a frame is already running on the bus
    repeat (3) pix(1'b1, 1'b0, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_stat_pix", stat_pix, 12'd0);
    chk("rst_stat_lines", stat_lines, 12'd0);
    chk("rst_fd", frame_done, 1'b0);
    sys_rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 8'(i));
      pix(1'b1, 1'b0, 8'h00);
    end
    pix(1'b0, 1'b0, 8'h00);
    pix(1'b0, 1'b0, 8'h00);
    chk("midrst_words", q.size(), 0);
    chk("midrst_fd", n_fd, 0);

    // Nominal frame: 10 lines of 100 bytes 0..99
    clear_obs();
    send_frame(10, 100, 100, 8'h00, 1'b0);
    chk("nom_words", q.size(), 250);
    chk("nom_first", q[0], wd(32'h03020100, 4'hF, 1'b1, 1'b0));
    chk("nom_eol0", q[24], wd(32'h63626160, 4'hF, 1'b0, 1'b1));
    chk("nom_line2", q[25], wd(32'h03020100, 4'hF, 1'b0, 1'b0));
    chk("nom_last", q[249], wd(32'h63626160, 4'hF, 1'b0, 1'b1));
    n_eol = 0; n_sof = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][0]) n_eol++;
      if (q[i][1]) n_sof++;
    end
    chk("nom_n_eol", n_eol, 10);
    chk("nom_n_sof", n_sof, 1);
    chk("nom_fd", n_fd, 1);
    chk("nom_el", n_el, 0);
    chk("nom_ef", n_ef, 0);
    chk("nom_stat_pix", stat_pix, 12'd100);
    chk("nom_stat_lines", stat_lines, 12'd10);

    // Short line of 6 bytes A0..A5
    clear_obs();
    send_frame(1, 0, 6, 8'hA0, 1'b0);
    chk("short_words", q.size(), 2);
    chk("short_w0", q[0], wd(32'hA3A2A1A0, 4'hF, 1'b1, 1'b0));
    chk("short_w1", q[1], wd(32'h0000A5A4, 4'h3, 1'b0, 1'b1));
    chk("short_el", n_el, 1);
    chk("short_stat_pix", stat_pix, 12'd6);
    chk("short_fd", n_fd, 1);

    // Single-byte line
    clear_obs();
    send_frame(1, 0, 1, 8'h5A, 1'b0);
    chk("single_words", q.size(), 1);
    chk("single_w0", q[0], wd(32'h0000005A, 4'h1, 1'b1, 1'b1));
    chk("single_stat_pix", stat_pix, 12'd1);

    // Frame of 9 lines
    clear_obs();
    send_frame(9, 100, 100, 8'h00, 1'b0);
    chk("len_words", q.size(), 225);
    chk("len_ef", n_ef, 1);
    chk("len_el", n_el, 0);
    chk("len_fd", n_fd, 1);
    chk("len_stat_lines", stat_lines, 12'd9);

    // fval falls with lval still high during an 8-byte line
    clear_obs();
    send_frame(2, 100, 8, 8'h10, 1'b1);
    chk("abr_words", q.size(), 27);
    chk("abr_w25", q[25], wd(32'h13121110, 4'hF, 1'b0, 1'b0));
    chk("abr_w26", q[26], wd(32'h17161514, 4'hF, 1'b0, 1'b1));
    chk("abr_fd", n_fd, 1);
    chk("abr_stat_lines", stat_lines, 12'd2);
    chk("abr_stat_pix", stat_pix, 12'd8);
    chk("abr_el", n_el, 1);
    chk("abr_ef", n_ef, 1);
    chk("abr_ovf", overflow, 1'b0);

    // Backpressure across a 100-byte line
    clear_obs();
    out_ready = 1'b0;
    send_frame(1, 0, 100, 8'h00, 1'b0);
    chk("bp_words", q.size(), 0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_head", out_data, 32'h03020100);
    chk("bp_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    #200;
    chk("bp_drain_n", q.size(), 4);
    chk("bp_d0", q[0], wd(32'h03020100, 4'hF, 1'b1, 1'b0));
    chk("bp_d1", q[1], wd(32'h07060504, 4'hF, 1'b0, 1'b0));
    chk("bp_d2", q[2], wd(32'h0B0A0908, 4'hF, 1'b0, 1'b0));
    chk("bp_d3", q[3], wd(32'h0F0E0D0C, 4'hF, 1'b0, 1'b0));
    chk("bp_ovf_sticky", overflow, 1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // Reset clears the sticky overflow
    sys_rst = 1'b1;
    #30;
    chk("rst2_ovf", overflow, 1'b0);
    chk("rst2_valid", out_valid, 1'b0);
    sys_rst = 1'b0;
    #20;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
